// File: rtl/g07_bus_pkg.sv
// g07_bus_pkg: shared FSM encoding, default slave address map and index-width helper.
package g07_bus_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_GRANT, ST_BUSY, ST_RELEASE, ST_ERR} state_e;
  localparam int DEF_SLV = 8;
  localparam logic [DEF_SLV-1:0][63:0] DEF_BASE = {
    64'h0000_0000_0007_0000, 64'h0000_0000_0006_0000, 64'h0000_0000_0005_0000,
    64'h0000_0000_0004_0000, 64'h0000_0000_0003_0000, 64'h0000_0000_0002_0000,
    64'h0000_0000_FFFF_D325, 64'h0000_0000_FFFE_7637};
  localparam logic [DEF_SLV-1:0][63:0] DEF_LIMIT = {
    64'h0000_0000_0007_FFFF, 64'h0000_0000_0006_FFFF, 64'h0000_0000_0005_FFFF,
    64'h0000_0000_0004_FFFF, 64'h0000_0000_0003_FFFF, 64'h0000_0000_0002_FFFF,
    64'h0000_0000_FFFF_D382, 64'h0000_0000_FFFE_7643};
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/g07_arb_picker.sv
// g07_arb_picker: combinational winner select, fixed priority or round-robin after last.
import g07_bus_pkg::*;
module g07_arb_picker #(
  parameter int N    = 7,
  parameter int MODE = 0,
  parameter int W    = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] idx
);
  logic [W-1:0] p;
  // scan from the lowest-priority candidate upward so the highest-priority hit is written last
  always_comb begin
    valid = |req;
    idx = '0;
    p = '0;
    for (int k = N; k >= 1; k--) begin
      p = (MODE != 0) ? W'((int'(last) + k) % N) : W'(k - 1);
      if (req[p]) idx = p;
    end
  end
endmodule

// File: rtl/g07_bus_arbiter_rr.sv
// g07_bus_arbiter_rr: bus arbiter with address decode, slave done handshake,
// per-transaction timeout and decode-miss error pulse.
import g07_bus_pkg::*;
module g07_bus_arbiter_rr #(
  parameter int NUM_MST  = 7,
  parameter int NUM_SLV  = 8,
  parameter int ADDR_W   = 64,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255,
  parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_BASE  = DEF_BASE,
  parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_LIMIT = DEF_LIMIT
) (
  input  logic                            sysClk,
  input  logic                            Breset,
  input  logic [NUM_MST-1:0]              m_need,
  input  logic [NUM_MST-1:0][ADDR_W-1:0]  m_addr,
  output logic [NUM_MST-1:0]              m_ack,
  output logic [NUM_MST-1:0]              m_err,
  output logic [NUM_SLV-1:0]              s_en,
  output logic [ADDR_W-1:0]               s_addr,
  input  logic [NUM_SLV-1:0]              s_tdone,
  output logic                            busy
);
  localparam int MW = idx_w(NUM_MST);
  localparam int SW = idx_w(NUM_SLV);
  state_e state_q, state_d;
  logic [MW-1:0] gnt_idx_q, gnt_idx_d, last_q, last_d, pick_idx;
  logic pick_valid;
  logic [SW-1:0] sel_q, sel_d, dec_idx, d;
  logic dec_hit;
  logic [ADDR_W-1:0] addr_q, addr_d, s_addr_q, s_addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [NUM_MST-1:0] ack_q, ack_d, err_q, err_d;
  logic [NUM_SLV-1:0] en_q, en_d;
  logic busy_q;

  g07_arb_picker #(.N(NUM_MST), .MODE(ARB_MODE), .W(MW)) u_pick (
    .req(m_need), .last(last_q), .valid(pick_valid), .idx(pick_idx)
  );

  // descending scan so the lowest matching region wins on overlap
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    d = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      d = SW'(i);
      if (addr_q >= SLV_BASE[d] && addr_q <= SLV_LIMIT[d]) begin
        dec_hit = 1'b1;
        dec_idx = d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_idx_d = gnt_idx_q;
    last_d = last_q;
    addr_d = addr_q;
    sel_d = sel_q;
    cnt_d = '0;
    ack_d = '0;
    err_d = '0;
    en_d = '0;
    s_addr_d = '0;
    case (state_q)
      ST_IDLE: if (pick_valid) begin
        state_d = ST_GRANT;
        gnt_idx_d = pick_idx;
        last_d = pick_idx;
        addr_d = m_addr[pick_idx];
        ack_d = NUM_MST'(1) << pick_idx;
      end
      ST_GRANT: if (dec_hit) begin
        state_d = ST_BUSY;
        sel_d = dec_idx;
        ack_d = ack_q;
        en_d = NUM_SLV'(1) << dec_idx;
        s_addr_d = addr_q;
      end else begin
        state_d = ST_ERR;
        err_d = NUM_MST'(1) << gnt_idx_q;
      end
      ST_BUSY: if (s_tdone[sel_q]) begin
        state_d = ST_RELEASE;
      end else if (TIMEOUT != 0 && cnt_q == 16'(TIMEOUT - 1)) begin
        state_d = ST_ERR;
        err_d = NUM_MST'(1) << gnt_idx_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
        ack_d = ack_q;
        en_d = en_q;
        s_addr_d = s_addr_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge Breset) begin
    if (!Breset) begin
      state_q <= ST_IDLE;
      gnt_idx_q <= '0;
      last_q <= MW'(NUM_MST - 1);
      addr_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      ack_q <= '0;
      err_q <= '0;
      en_q <= '0;
      s_addr_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_idx_q <= gnt_idx_d;
      last_q <= last_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      err_q <= err_d;
      en_q <= en_d;
      s_addr_q <= s_addr_d;
      busy_q <= state_d != ST_IDLE;
    end
  end

  assign m_ack = ack_q;
  assign m_err = err_q;
  assign s_en = en_q;
  assign s_addr = s_addr_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_g07_bus_arbiter_rr.sv
// tb_g07_bus_arbiter_rr: directed scoreboard bench for fixed (timeout 8) and round-robin arbiters.
module tb_g07_bus_arbiter_rr;
  logic sysClk = 1'b0;
  logic Breset = 1'b0;
  logic [6:0] m_need = '0;
  logic [6:0][63:0] m_addr = '0;
  logic [7:0] s_tdone = '0;
  logic [6:0] ack0, err0, ack1, err1;
  logic [7:0] en0, en1;
  logic [63:0] sa0, sa1;
  logic busy0, busy1;
  logic which = 1'b0;
  logic [86:0] obs;
  int total = 0;
  int bad = 0;
  typedef struct {
    string tag;
    logic [86:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 sysClk = ~sysClk;

  g07_bus_arbiter_rr #(.ARB_MODE(0), .TIMEOUT(8)) dut_fix (
    .sysClk(sysClk), .Breset(Breset), .m_need(m_need), .m_addr(m_addr),
    .m_ack(ack0), .m_err(err0), .s_en(en0), .s_addr(sa0), .s_tdone(s_tdone), .busy(busy0)
  );
  g07_bus_arbiter_rr #(.ARB_MODE(1)) dut_rr (
    .sysClk(sysClk), .Breset(Breset), .m_need(m_need), .m_addr(m_addr),
    .m_ack(ack1), .m_err(err1), .s_en(en1), .s_addr(sa1), .s_tdone(s_tdone), .busy(busy1)
  );

  assign obs = which ? {ack1, err1, en1, sa1, busy1} : {ack0, err0, en0, sa0, busy0};

  task automatic push(input string tag, input logic [6:0] a, input logic [6:0] e,
                      input logic [7:0] en, input logic [63:0] ad, input logic b);
    exp_t x;
    x.tag = tag;
    x.v = {a, e, en, ad, b};
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    x = sb.pop_front();
    total++;
    assert (obs === x.v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.v);
    end
  endtask

  task automatic tick(input string tag, input logic [6:0] a, input logic [6:0] e,
                      input logic [7:0] en, input logic [63:0] ad, input logic b);
    push(tag, a, e, en, ad, b);
    @(posedge sysClk);
    #1;
    check();
  endtask

  task automatic txn(input string tag, input int g);
    tick({tag, "_grant"}, 7'(1) << g, '0, '0, '0, 1'b1);
    tick({tag, "_busy"}, 7'(1) << g, '0, 8'h02, 64'hFFFF_D330, 1'b1);
    s_tdone[1] = 1'b1;
    tick({tag, "_release"}, '0, '0, '0, '0, 1'b1);
    s_tdone = '0;
    tick({tag, "_idle"}, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    m_need = '0;
    s_tdone = '0;
    Breset = 1'b0;
    #3;
    Breset = 1'b1;
  endtask

  initial begin
    #12;
    push("reset_low", '0, '0, '0, '0, 1'b0);
    check();
    #1;
    Breset = 1'b1;
    tick("reset_idle0", '0, '0, '0, '0, 1'b0);
    tick("reset_idle1", '0, '0, '0, '0, 1'b0);

    m_need[2] = 1'b1;
    m_addr[2] = 64'hFFFF_D330;
    tick("single_grant", 7'b0000100, '0, '0, '0, 1'b1);
    m_need = '0;
    tick("single_busy", 7'b0000100, '0, 8'h02, 64'hFFFF_D330, 1'b1);
    s_tdone[1] = 1'b1;
    tick("single_release", '0, '0, '0, '0, 1'b1);
    s_tdone = '0;
    tick("single_idle", '0, '0, '0, '0, 1'b0);

    m_addr[4] = 64'hFFFF_D330;
    m_addr[6] = 64'hFFFF_D330;
    m_need = 7'b1010100;
    txn("prio0", 2);
    txn("prio1", 2);
    txn("prio2", 2);

    do_reset();
    which = 1'b1;
    m_need = 7'b1010100;
    txn("rr0", 2);
    txn("rr1", 4);
    txn("rr2", 6);
    txn("rr3", 2);
    m_need = '0;
    tick("rr_quiet", '0, '0, '0, '0, 1'b0);

    do_reset();
    which = 1'b0;
    m_addr[0] = 64'h0;
    m_need[0] = 1'b1;
    tick("miss_grant", 7'b0000001, '0, '0, '0, 1'b1);
    m_need = '0;
    tick("miss_err", '0, 7'b0000001, '0, '0, 1'b1);
    tick("miss_idle", '0, '0, '0, '0, 1'b0);
    tick("miss_quiet", '0, '0, '0, '0, 1'b0);

    do_reset();
    m_addr[0] = 64'hFFFE_7640;
    m_need[0] = 1'b1;
    tick("to_grant", 7'b0000001, '0, '0, '0, 1'b1);
    m_need = '0;
    tick("to_busy0", 7'b0000001, '0, 8'h01, 64'hFFFE_7640, 1'b1);
    s_tdone[3] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick("to_busy", 7'b0000001, '0, 8'h01, 64'hFFFE_7640, 1'b1);
      s_tdone = '0;
    end
    tick("to_err", '0, 7'b0000001, '0, '0, 1'b1);
    tick("to_idle", '0, '0, '0, '0, 1'b0);
    m_addr[1] = 64'hFFFF_D330;
    m_need[1] = 1'b1;
    tick("after_grant", 7'b0000010, '0, '0, '0, 1'b1);
    m_need = '0;
    tick("after_busy", 7'b0000010, '0, 8'h02, 64'hFFFF_D330, 1'b1);
    s_tdone[1] = 1'b1;
    tick("after_release", '0, '0, '0, '0, 1'b1);
    s_tdone = '0;
    tick("after_idle", '0, '0, '0, '0, 1'b0);

    m_need[2] = 1'b1;
    tick("midrst_grant", 7'b0000100, '0, '0, '0, 1'b1);
    m_need = '0;
    tick("midrst_busy", 7'b0000100, '0, 8'h02, 64'hFFFF_D330, 1'b1);
    Breset = 1'b0;
    #2;
    push("midrst_async", '0, '0, '0, '0, 1'b0);
    check();
    #2;
    Breset = 1'b1;
    tick("midrst_idle", '0, '0, '0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
